// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle for the two-wide instruction queue.
// The slave modport is the queue itself; the master modport is the fetch/decode side.
interface fetch_queue_if #(
  parameter int DEPTH   = 8,
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic               flush;
  logic               in_valid0;
  logic [INSTR_W-1:0] in_instr0;
  logic [PC_W-1:0]    in_pc0;
  logic               in_valid1;
  logic [INSTR_W-1:0] in_instr1;
  logic [PC_W-1:0]    in_pc1;
  logic               in_ready;
  logic               out_valid0;
  logic [INSTR_W-1:0] out_instr0;
  logic [PC_W-1:0]    out_pc0;
  logic               out_valid1;
  logic [INSTR_W-1:0] out_instr1;
  logic [PC_W-1:0]    out_pc1;
  logic [1:0]         out_take;
  logic [CW-1:0]      count;

  modport slave (
    input  flush, in_valid0, in_instr0, in_pc0, in_valid1, in_instr1, in_pc1, out_take,
    output in_ready, out_valid0, out_instr0, out_pc0, out_valid1, out_instr1, out_pc1, count
  );

  modport master (
    output flush, in_valid0, in_instr0, in_pc0, in_valid1, in_instr1, in_pc1, out_take,
    input  in_ready, out_valid0, out_instr0, out_pc0, out_valid1, out_instr1, out_pc1, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Two-wide in-order instruction queue between fetch and decode.
// Accepts 0-2 entries and retires 0-2 entries per cycle; flushed on redirect.
module fetch_queue #(
  parameter int DEPTH   = 8,
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  fetch_queue_if.slave fq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [INSTR_W-1:0] instr_q [DEPTH];
  logic [PC_W-1:0]    pc_q    [DEPTH];
  logic [AW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [AW-1:0]      head_p1_s, tail_p1_s;
  logic [CW-1:0]      count_q, count_d;

  logic               in_ready_s;
  logic [1:0]         take_s, deq_s, enq_s;
  logic               wr0_s, wr1_s;
  logic [INSTR_W-1:0] wr0_instr_s;
  logic [PC_W-1:0]    wr0_pc_s;

  assign head_p1_s  = head_q + AW'(1);
  assign tail_p1_s  = tail_q + AW'(1);
  // Conservative: a same-cycle dequeue is not credited toward room.
  assign in_ready_s = (count_q <= CW'(DEPTH - 2));

  // Clamp the decode take request to what is actually held.
  always_comb begin
    take_s = fq.out_take;
    deq_s  = 2'd0;
    if (fq.out_take == 2'd3) begin
      take_s = 2'd2;
    end else begin
      take_s = fq.out_take;
    end
    if (count_q >= CW'(take_s)) begin
      deq_s = take_s;
    end else begin
      deq_s = count_q[1:0];
    end
  end

  // Enqueue count and lane steering; a lone slot 1 lands at tail.
  always_comb begin
    enq_s       = 2'd0;
    wr0_instr_s = fq.in_instr0;
    wr0_pc_s    = fq.in_pc0;
    if (in_ready_s && !fq.flush) begin
      enq_s = {1'b0, fq.in_valid0} + {1'b0, fq.in_valid1};
    end else begin
      enq_s = 2'd0;
    end
    if (fq.in_valid0) begin
      wr0_instr_s = fq.in_instr0;
      wr0_pc_s    = fq.in_pc0;
    end else begin
      wr0_instr_s = fq.in_instr1;
      wr0_pc_s    = fq.in_pc1;
    end
  end

  assign wr0_s = (enq_s != 2'd0);
  assign wr1_s = (enq_s == 2'd2);

  // Pointer and occupancy next-state; flush overrides enqueue and dequeue.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (fq.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + AW'(deq_s);
      tail_d  = tail_q + AW'(enq_s);
      count_d = count_q + CW'(enq_s) - CW'(deq_s);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; cleared only by reset, never by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      if (wr0_s) begin
        instr_q[tail_q] <= wr0_instr_s;
        pc_q[tail_q]    <= wr0_pc_s;
      end
      if (wr1_s) begin
        instr_q[tail_p1_s] <= fq.in_instr1;
        pc_q[tail_p1_s]    <= fq.in_pc1;
      end
    end
  end

  assign fq.in_ready   = in_ready_s;
  assign fq.count      = count_q;
  assign fq.out_valid0 = (count_q != CW'(0));
  assign fq.out_valid1 = (count_q >= CW'(2));
  assign fq.out_instr0 = instr_q[head_q];
  assign fq.out_pc0    = pc_q[head_q];
  assign fq.out_instr1 = instr_q[head_p1_s];
  assign fq.out_pc1    = pc_q[head_p1_s];
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_fetch_queue;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [63:0] mq[$];

  fetch_queue_if #(.DEPTH(DEPTH), .INSTR_W(32), .PC_W(32)) fq ();
  fetch_queue #(.DEPTH(DEPTH), .INSTR_W(32), .PC_W(32)) dut (.clk(clk), .rst_n(rst_n), .fq(fq));

  always #5 clk = ~clk;

  // Drive one cycle of stimulus, advance the model at the edge, return at the negedge.
  task automatic step(input bit f, input bit v0, input logic [31:0] i0, input logic [31:0] p0,
                      input bit v1, input logic [31:0] i1, input logic [31:0] p1,
                      input logic [1:0] take);
    int tk, d;
    bit rdy;
    fq.flush = f; fq.in_valid0 = v0; fq.in_instr0 = i0; fq.in_pc0 = p0;
    fq.in_valid1 = v1; fq.in_instr1 = i1; fq.in_pc1 = p1; fq.out_take = take;
    @(posedge clk);
    tk = (take == 2'd3) ? 2 : int'(take);
    if (f) begin
      mq.delete();
    end else begin
      rdy = (mq.size() <= DEPTH - 2);
      d = (tk < mq.size()) ? tk : mq.size();
      repeat (d) void'(mq.pop_front());
      if (rdy && v0) mq.push_back({i0, p0});
      if (rdy && v1) mq.push_back({i1, p1});
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    fq.flush = 1'b0; fq.in_valid0 = 1'b0; fq.in_instr0 = '0; fq.in_pc0 = '0;
    fq.in_valid1 = 1'b0; fq.in_instr1 = '0; fq.in_pc1 = '0; fq.out_take = 2'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    #12;
    n_checks++;
    if (fq.count !== 4'd0 || fq.out_valid0 !== 1'b0 || fq.out_valid1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: count=%0d v0=%b v1=%b required 0 0 0", fq.count, fq.out_valid0, fq.out_valid1);
    end
    n_checks++;
    if (fq.out_instr0 !== 32'h0 || fq.out_pc0 !== 32'h0 || fq.out_instr1 !== 32'h0 || fq.out_pc1 !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: %h %h %h %h required all 0", fq.out_instr0, fq.out_pc0, fq.out_instr1, fq.out_pc1);
    end
    n_checks++;
    if (fq.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b required 1", fq.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
  endtask

  task automatic test_basic_flow();
    step(1'b0, 1'b1, 32'h08000001, 32'h100, 1'b1, 32'h10400002, 32'h104, 2'd0);
    n_checks++;
    if (fq.count !== 4'd2 || fq.out_valid0 !== 1'b1 || fq.out_valid1 !== 1'b1) begin
      n_fail++; $display("FAIL basic_valid: count=%0d v0=%b v1=%b required 2 1 1", fq.count, fq.out_valid0, fq.out_valid1);
    end
    n_checks++;
    if (fq.out_instr0 !== 32'h08000001 || fq.out_pc1 !== 32'h104) begin
      n_fail++; $display("FAIL basic_data: instr0=%h pc1=%h required 08000001 00000104", fq.out_instr0, fq.out_pc1);
    end
  endtask

  task automatic test_fill_full();
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 2'd0);
    for (int k = 0; k < 4; k++)
      step(1'b0, 1'b1, 32'hA000_0000 + 32'(k), 32'h400 + 32'(8 * k), 1'b1, 32'hB000_0000 + 32'(k), 32'h404 + 32'(8 * k), 2'd0);
    n_checks++;
    if (fq.count !== 4'd8 || fq.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_state: count=%0d ready=%b required 8 0", fq.count, fq.in_ready);
    end
    step(1'b0, 1'b1, 32'hDEADBEEF, 32'h500, 1'b0, 32'h0, 32'h0, 2'd0);
    n_checks++;
    if (fq.count !== 4'd8 || fq.out_instr0 !== 32'hA0000000) begin
      n_fail++; $display("FAIL full_refuse: count=%0d instr0=%h required 8 a0000000", fq.count, fq.out_instr0);
    end
    // Drain to 7 and confirm a single enqueue is still refused.
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 2'd1);
    n_checks++;
    if (fq.count !== 4'd7 || fq.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL seven_ready: count=%0d ready=%b required 7 0", fq.count, fq.in_ready);
    end
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hDEADBEEF, 32'h600, 2'd0);
    n_checks++;
    if (fq.count !== 4'd7 || fq.out_pc0 !== 32'h404) begin
      n_fail++; $display("FAIL seven_refuse: count=%0d pc0=%h required 7 00000404", fq.count, fq.out_pc0);
    end
  endtask

  task automatic test_wrap();
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 2'd0);
    step(1'b0, 1'b1, 32'hC0000000, 32'h200, 1'b1, 32'hC0000001, 32'h204, 2'd0);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1, 32'hC1000000 + 32'(k), 32'h208 + 32'(8 * k),
           1'b1, 32'hC2000000 + 32'(k), 32'h20C + 32'(8 * k), 2'd2);
      n_checks++;
      if (fq.count !== 4'd2 || fq.out_pc0 !== 32'h208 + 32'(8 * k) || fq.out_pc1 !== 32'h20C + 32'(8 * k)) begin
        n_fail++; $display("FAIL wrap_%0d: count=%0d pc0=%h pc1=%h required 2 %h %h", k, fq.count,
                           fq.out_pc0, fq.out_pc1, 32'h208 + 32'(8 * k), 32'h20C + 32'(8 * k));
      end
    end
  endtask

  task automatic test_odd_lane();
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 2'd0);
    step(1'b0, 1'b0, 32'h11111111, 32'h2F0, 1'b1, 32'h20000003, 32'h300, 2'd0);
    n_checks++;
    if (fq.count !== 4'd1 || fq.out_valid0 !== 1'b1 || fq.out_valid1 !== 1'b0 ||
        fq.out_instr0 !== 32'h20000003 || fq.out_pc0 !== 32'h300) begin
      n_fail++; $display("FAIL odd_lane: count=%0d v0=%b v1=%b instr0=%h pc0=%h required 1 1 0 20000003 00000300",
                         fq.count, fq.out_valid0, fq.out_valid1, fq.out_instr0, fq.out_pc0);
    end
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 2'd2);
    n_checks++;
    if (fq.count !== 4'd0 || fq.out_valid0 !== 1'b0) begin
      n_fail++; $display("FAIL take_clamp: count=%0d v0=%b required 0 0", fq.count, fq.out_valid0);
    end
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 2'd3);
    n_checks++;
    if (fq.count !== 4'd0 || fq.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL empty_take: count=%0d ready=%b required 0 1", fq.count, fq.in_ready);
    end
  endtask

  task automatic test_flush();
    step(1'b0, 1'b1, 32'hE0, 32'h700, 1'b1, 32'hE1, 32'h704, 2'd0);
    step(1'b0, 1'b1, 32'hE2, 32'h708, 1'b1, 32'hE3, 32'h70C, 2'd0);
    step(1'b0, 1'b1, 32'hE4, 32'h710, 1'b0, 32'h0, 32'h0, 2'd0);
    n_checks++;
    if (fq.count !== 4'd5) begin
      n_fail++; $display("FAIL flush_setup: count=%0d required 5", fq.count);
    end
    step(1'b1, 1'b1, 32'hF0, 32'h800, 1'b1, 32'hF1, 32'h804, 2'd2);
    n_checks++;
    if (fq.count !== 4'd0 || fq.out_valid0 !== 1'b0 || fq.out_valid1 !== 1'b0 || fq.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_state: count=%0d v0=%b v1=%b ready=%b required 0 0 0 1",
                         fq.count, fq.out_valid0, fq.out_valid1, fq.in_ready);
    end
    step(1'b0, 1'b1, 32'h12345678, 32'h900, 1'b0, 32'h0, 32'h0, 2'd0);
    n_checks++;
    if (fq.count !== 4'd1 || fq.out_instr0 !== 32'h12345678 || fq.out_pc0 !== 32'h900) begin
      n_fail++; $display("FAIL post_flush: count=%0d instr0=%h pc0=%h required 1 12345678 00000900",
                         fq.count, fq.out_instr0, fq.out_pc0);
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 2'd0);
    for (int k = 0; k < 3; k++)
      step(1'b0, 1'b1, 32'hAB00 + 32'(k), 32'hA00 + 32'(8 * k), 1'b1, 32'hCD00 + 32'(k), 32'hA04 + 32'(8 * k), 2'd0);
    n_checks++;
    if (fq.count !== 4'd6) begin
      n_fail++; $display("FAIL async_setup: count=%0d required 6", fq.count);
    end
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (fq.count !== 4'd0 || fq.out_valid0 !== 1'b0 || fq.out_instr0 !== 32'h0) begin
      n_fail++; $display("FAIL async_reset: count=%0d v0=%b instr0=%h required 0 0 00000000",
                         fq.count, fq.out_valid0, fq.out_instr0);
    end
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    bit f, v0, v1;
    logic [1:0] tk;
    for (int c = 0; c < 400; c++) begin
      f  = ($urandom_range(0, 19) == 0);
      v0 = $urandom_range(0, 1);
      v1 = $urandom_range(0, 1);
      tk = 2'($urandom_range(0, 3));
      step(f, v0, $urandom, $urandom, v1, $urandom, $urandom, tk);
      n_checks++;
      if (fq.count !== 4'(mq.size()) || fq.in_ready !== (mq.size() <= DEPTH - 2)) begin
        n_fail++; $display("FAIL rand_count_%0d: count=%0d ready=%b required %0d %b", c, fq.count,
                           fq.in_ready, mq.size(), (mq.size() <= DEPTH - 2));
      end
      n_checks++;
      if (fq.out_valid0 !== (mq.size() >= 1) || fq.out_valid1 !== (mq.size() >= 2)) begin
        n_fail++; $display("FAIL rand_valid_%0d: v0=%b v1=%b size=%0d", c, fq.out_valid0, fq.out_valid1, mq.size());
      end
      if (mq.size() >= 1) begin
        n_checks++;
        if ({fq.out_instr0, fq.out_pc0} !== mq[0]) begin
          n_fail++; $display("FAIL rand_lane0_%0d: got %h required %h", c, {fq.out_instr0, fq.out_pc0}, mq[0]);
        end
      end
      if (mq.size() >= 2) begin
        n_checks++;
        if ({fq.out_instr1, fq.out_pc1} !== mq[1]) begin
          n_fail++; $display("FAIL rand_lane1_%0d: got %h required %h", c, {fq.out_instr1, fq.out_pc1}, mq[1]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_flow();
    test_fill_full();
    test_wrap();
    test_odd_lane();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
